dmem_port_arbiter: RTL and testbench

- Two-requester access controller in front of the word-organised data memory (32-bit words, 4-bit byte write enable, memory clocked on inverted clk).
- Requester C is the core load/store unit; requester D is the debug/DMA loader.
- Block arbitrates between C and D, sequences each access through a fixed 3-state FSM, builds byte enables, replicates store lanes, extracts and extends load data, and flags misaligned or illegal accesses.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_lane_align.sv | 73 +++++++
 rtl/dmem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and funct3 encodings for the data-memory port arbiter.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic {
        OWN_C,
        OWN_D
    } owner_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores, load extraction/extension, and access legality check.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2:0]        funct3,
    input  logic              we,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] load_data,
    output logic              err
);

    logic        illegal;
    logic        misaligned;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = mem_rdata[{offset, 3'b000} +: 8];
    assign rd_half = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        mem_wr     = 4'b0000;
        mem_wdata  = '0;
        load_data  = '0;
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (funct3)
            F3_B: begin
                mem_wr    = 4'b0001 << offset;
                mem_wdata = {4{wdata[7:0]}};
                load_data = {{24{rd_byte[7]}}, rd_byte};
            end
            F3_H: begin
                misaligned = offset[0];
                mem_wr     = offset[1] ? 4'b1100 : 4'b0011;
                mem_wdata  = {2{wdata[15:0]}};
                load_data  = {{16{rd_half[15]}}, rd_half};
            end
            F3_W: begin
                misaligned = (offset != 2'b00);
                mem_wr     = 4'b1111;
                mem_wdata  = wdata;
                load_data  = mem_rdata;
            end
            F3_BU: begin
                illegal   = we;
                load_data = {24'h000000, rd_byte};
            end
            F3_HU: begin
                illegal    = we;
                misaligned = offset[0];
                load_data  = {16'h0000, rd_half};
            end
            default: illegal = 1'b1;
        endcase

        err = illegal | misaligned;
        // Loads and faulting accesses never touch memory; stores and faults return zero data.
        if (err || !we) begin
            mem_wr    = 4'b0000;
            mem_wdata = '0;
        end
        if (err || we) begin
            load_data = '0;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester data-memory front end: C-priority arbitration with D starvation guard,
// fixed IDLE/ACCESS/RESP sequencing, one access in flight.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  c_req_valid,
    output logic                  c_req_ready,
    input  logic                  c_we,
    input  logic [2:0]            c_funct3,
    input  logic [DM_ADDRESS-1:0] c_addr,
    input  logic [DATA_W-1:0]     c_wdata,
    output logic                  c_rsp_valid,
    output logic                  c_rsp_err,
    output logic [DATA_W-1:0]     c_rdata,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic                  d_we,
    input  logic [2:0]            d_funct3,
    input  logic [DM_ADDRESS-1:0] d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_rsp_valid,
    output logic                  d_rsp_err,
    output logic [DATA_W-1:0]     d_rdata,
    output logic [31:0]           mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [3:0]            mem_wr,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [WaitW-1:0]      wait_q, wait_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;

    logic                  grant_c, grant_d, force_d;
    logic [3:0]            lane_wr;
    logic [DATA_W-1:0]     lane_wdata;
    logic [DATA_W-1:0]     lane_rdata;
    logic                  lane_err;

    dmem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .funct3    (funct3_q),
        .we        (we_q),
        .offset    (addr_q[1:0]),
        .wdata     (wdata_q),
        .mem_rdata (mem_rdata),
        .mem_wr    (lane_wr),
        .mem_wdata (lane_wdata),
        .load_data (lane_rdata),
        .err       (lane_err)
    );

    assign force_d = d_req_valid && (wait_q == WaitW'(MAX_WAIT));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wait_d      = wait_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        grant_c     = 1'b0;
        grant_d     = 1'b0;

        if (!d_req_valid) begin
            wait_d = '0;
        end

        case (state_q)
            IDLE: begin
                grant_d = d_req_valid && (force_d || !c_req_valid);
                grant_c = c_req_valid && !grant_d;
                if (grant_c) begin
                    owner_d  = OWN_C;
                    we_d     = c_we;
                    funct3_d = c_funct3;
                    addr_d   = c_addr;
                    wdata_d  = c_wdata;
                    state_d  = ACCESS;
                end else if (grant_d) begin
                    owner_d  = OWN_D;
                    we_d     = d_we;
                    funct3_d = d_funct3;
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                    state_d  = ACCESS;
                end
                if (!d_req_valid || grant_d) begin
                    wait_d = '0;
                end else if (wait_q != WaitW'(MAX_WAIT)) begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = lane_err;
                rsp_rdata_d = lane_rdata;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_C;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wait_q      <= wait_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Ready is gated by reset so every output reads zero while rst_n is held low.
    assign c_req_ready = rst_n && grant_c;
    assign d_req_ready = rst_n && grant_d;

    // Address stays up through RESP so the inverted-clock memory keeps returning the same word.
    assign mem_addr  = (state_q != IDLE)
                     ? {{(32 - DM_ADDRESS){1'b0}}, addr_q[DM_ADDRESS-1:2], 2'b00} : 32'h0;
    assign mem_wr    = (state_q == ACCESS) ? lane_wr : 4'b0000;
    assign mem_wdata = (state_q == ACCESS) ? lane_wdata : '0;

    assign c_rsp_valid = rsp_valid_q && (owner_q == OWN_C);
    assign c_rsp_err   = rsp_err_q && (owner_q == OWN_C);
    assign c_rdata     = (owner_q == OWN_C) ? rsp_rdata_q : '0;
    assign d_rsp_valid = rsp_valid_q && (owner_q == OWN_D);
    assign d_rsp_err   = rsp_err_q && (owner_q == OWN_D);
    assign d_rdata     = (owner_q == OWN_D) ? rsp_rdata_q : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a byte-enabled memory model on the inverted clock.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_req_valid, c_req_ready, c_we, c_rsp_valid, c_rsp_err;
    logic [2:0]  c_funct3;
    logic [8:0]  c_addr;
    logic [31:0] c_wdata, c_rdata;
    logic        d_req_valid, d_req_ready, d_we, d_rsp_valid, d_rsp_err;
    logic [2:0]  d_funct3;
    logic [8:0]  d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wr;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] mem [128] = '{default: 32'h0};

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  exp_wr;
        logic [31:0] exp_mwd;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    dmem_port_arbiter #(
        .DM_ADDRESS (9),
        .DATA_W     (32),
        .MAX_WAIT   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .c_req_valid (c_req_valid),
        .c_req_ready (c_req_ready),
        .c_we        (c_we),
        .c_funct3    (c_funct3),
        .c_addr      (c_addr),
        .c_wdata     (c_wdata),
        .c_rsp_valid (c_rsp_valid),
        .c_rsp_err   (c_rsp_err),
        .c_rdata     (c_rdata),
        .d_req_valid (d_req_valid),
        .d_req_ready (d_req_ready),
        .d_we        (d_we),
        .d_funct3    (d_funct3),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_err   (d_rsp_err),
        .d_rdata     (d_rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wr      (mem_wr),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_wr[b]) mem[mem_addr[8:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
        mem_rdata <= mem[mem_addr[8:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " c_req_ready"}, 32'(c_req_ready), 32'h0);
        check({tag, " d_req_ready"}, 32'(d_req_ready), 32'h0);
        check({tag, " rsp_valid"}, 32'({c_rsp_valid, d_rsp_valid}), 32'h0);
        check({tag, " rsp_err"}, 32'({c_rsp_err, d_rsp_err}), 32'h0);
        check({tag, " c_rdata"}, c_rdata, 32'h0);
        check({tag, " d_rdata"}, d_rdata, 32'h0);
        check({tag, " mem_addr"}, mem_addr, 32'h0);
        check({tag, " mem_wdata"}, mem_wdata, 32'h0);
        check({tag, " mem_wr"}, 32'(mem_wr), 32'h0);
    endtask

    // One C-port access: accept, check the memory cycle, then the response pulse.
    task automatic run_vec(input vec_t v, input string tag);
        bit seen = 0;
        @(posedge clk); #1;
        c_req_valid = 1'b1;
        c_we        = v.we;
        c_funct3    = v.f3;
        c_addr      = v.addr;
        c_wdata     = v.wdata;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (c_req_ready) seen = 1;
        end
        check({tag, " accepted"}, 32'(seen), 32'h1);
        @(posedge clk); #1;
        c_req_valid = 1'b0;
        @(negedge clk);
        check({tag, " mem_wr"}, 32'(mem_wr), 32'(v.exp_wr));
        if (v.exp_wr != 4'b0000) check({tag, " mem_wdata"}, mem_wdata, v.exp_mwd);
        check({tag, " mem_addr"}, mem_addr, {23'h0, v.addr[8:2], 2'b00});
        @(negedge clk);
        check({tag, " early rsp_valid"}, 32'(c_rsp_valid), 32'h0);
        @(negedge clk);
        check({tag, " rsp_valid"}, 32'(c_rsp_valid), 32'h1);
        check({tag, " rsp_err"}, 32'(c_rsp_err), 32'(v.exp_err));
        check({tag, " rdata"}, c_rdata, v.exp_rdata);
        check({tag, " d_rsp_valid"}, 32'(d_rsp_valid), 32'h0);
    endtask

    initial begin
        int  n_c;
        bit  got_d;
        bit  both;
        bit  stray;
        vec_t v;

        rst_n = 1'b0;
        c_req_valid = 0; c_we = 0; c_funct3 = 0; c_addr = 0; c_wdata = 0;
        d_req_valid = 0; d_we = 0; d_funct3 = 0; d_addr = 0; d_wdata = 0;

        vecs[0]  = '{1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 3'b010, 9'h010, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 3'b000, 9'h013, 32'h000000A5, 4'h8, 32'hA5A5A5A5, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 3'b000, 9'h013, 32'h0, 4'h0, 32'h0, 32'hFFFFFFA5, 1'b0};
        vecs[4]  = '{1'b0, 3'b100, 9'h013, 32'h0, 4'h0, 32'h0, 32'h000000A5, 1'b0};
        vecs[5]  = '{1'b1, 3'b001, 9'h022, 32'h00008001, 4'hC, 32'h80018001, 32'h0, 1'b0};
        vecs[6]  = '{1'b0, 3'b001, 9'h022, 32'h0, 4'h0, 32'h0, 32'hFFFF8001, 1'b0};
        vecs[7]  = '{1'b0, 3'b101, 9'h022, 32'h0, 4'h0, 32'h0, 32'h00008001, 1'b0};
        vecs[8]  = '{1'b0, 3'b010, 9'h011, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1};
        vecs[9]  = '{1'b1, 3'b001, 9'h021, 32'h00001234, 4'h0, 32'h0, 32'h0, 1'b1};
        vecs[10] = '{1'b1, 3'b011, 9'h020, 32'hFFFFFFFF, 4'h0, 32'h0, 32'h0, 1'b1};
        vecs[11] = '{1'b0, 3'b110, 9'h010, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1};
        vecs[12] = '{1'b0, 3'b010, 9'h020, 32'h0, 4'h0, 32'h0, 32'h80010000, 1'b0};
        vecs[13] = '{1'b0, 3'b010, 9'h010, 32'h0, 4'h0, 32'h0, 32'hA5ADBEEF, 1'b0};
        vecs[14] = '{1'b0, 3'b000, 9'h012, 32'h0, 4'h0, 32'h0, 32'hFFFFFFAD, 1'b0};
        vecs[15] = '{1'b0, 3'b100, 9'h011, 32'h0, 4'h0, 32'h0, 32'h000000BE, 1'b0};
        vecs[16] = '{1'b0, 3'b001, 9'h010, 32'h0, 4'h0, 32'h0, 32'hFFFFBEEF, 1'b0};
        vecs[17] = '{1'b0, 3'b101, 9'h012, 32'h0, 4'h0, 32'h0, 32'h0000A5AD, 1'b0};
        vecs[18] = '{1'b1, 3'b000, 9'h000, 32'h0000007F, 4'h1, 32'h7F7F7F7F, 32'h0, 1'b0};
        vecs[19] = '{1'b0, 3'b000, 9'h000, 32'h0, 4'h0, 32'h0, 32'h0000007F, 1'b0};
        vecs[20] = '{1'b1, 3'b001, 9'h020, 32'h00005566, 4'h3, 32'h55665566, 32'h0, 1'b0};
        vecs[21] = '{1'b0, 3'b010, 9'h020, 32'h0, 4'h0, 32'h0, 32'h80015566, 1'b0};

        repeat (3) @(posedge clk);
        #1 check_all_zero("in_reset");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) check_all_zero("after_reset");

        for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Both requesters held: C wins eight times, then D is forced through.
        @(posedge clk); #1;
        c_req_valid = 1; c_we = 0; c_funct3 = 3'b010; c_addr = 9'h010;
        d_req_valid = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 9'h020;
        n_c = 0; got_d = 0; both = 0;
        for (int k = 0; k < 60 && !got_d; k++) begin
            @(negedge clk);
            if (c_req_ready && d_req_ready) both = 1;
            if (d_req_ready) got_d = 1;
            else if (c_req_ready) n_c++;
        end
        check("starve d_granted", 32'(got_d), 32'h1);
        check("starve c_grants_before_d", n_c, 8);
        check("starve exclusive_ready", 32'(both), 32'h0);
        @(posedge clk); #1;
        c_req_valid = 0; d_req_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check("starve d early rsp", 32'(d_rsp_valid), 32'h0);
        @(negedge clk);
        check("starve d_rsp_valid", 32'(d_rsp_valid), 32'h1);
        check("starve d_rdata", d_rdata, 32'h80015566);
        check("starve d_rsp_err", 32'(d_rsp_err), 32'h0);
        check("starve c_rsp_valid", 32'(c_rsp_valid), 32'h0);
        check("starve c_rdata", c_rdata, 32'h0);
        @(posedge clk); #1;
        c_req_valid = 1; d_req_valid = 1;
        @(negedge clk);
        check("counter cleared c_ready", 32'(c_req_ready), 32'h1);
        check("counter cleared d_ready", 32'(d_req_ready), 32'h0);
        @(posedge clk); #1;
        c_req_valid = 0; d_req_valid = 0;
        repeat (4) @(posedge clk);

        // Reset during the ACCESS cycle of a store.
        #1;
        c_req_valid = 1; c_we = 1; c_funct3 = 3'b010; c_addr = 9'h030; c_wdata = 32'h11223344;
        @(negedge clk);
        check("rst store accepted", 32'(c_req_ready), 32'h1);
        @(posedge clk); #1;
        c_req_valid = 0;
        check("rst mem_wr before", 32'(mem_wr), 32'hF);
        #1 rst_n = 1'b0;
        #1 check_all_zero("rst_mid_access");
        @(negedge clk) #1 rst_n = 1'b1;
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (c_rsp_valid || d_rsp_valid || mem_wr != 4'b0000) stray = 1;
        end
        check("rst no stray activity", 32'(stray), 32'h0);
        check_all_zero("rst_released");
        v = '{1'b0, 3'b010, 9'h030, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0};
        run_vec(v, "rst mem_untouched");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
